valid_pipe_fifo: RTL

VALID_PIPE_FIFO -- requirements
Module: valid_pipe_fifo

---
 rtl/valid_pipe_pkg.sv | 17 +
 rtl/valid_pipe_mem.sv | 26 ++
 rtl/valid_pipe_fifo.sv | 122 ++++++++++++
 3 files changed

// File: rtl/valid_pipe_pkg.sv
// Shared sizing helpers and parameter legality checks for the valid_pipe FIFO.
package valid_pipe_pkg;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Storage must be a power of two so pointers wrap by plain overflow.
  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/valid_pipe_mem.sv
// Unreset DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
module valid_pipe_mem
  import valid_pipe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [ptr_w(DEPTH)-1:0]    waddr_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic [ptr_w(DEPTH)-1:0]    raddr_i,
  output logic [DATA_W-1:0]          rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/valid_pipe_fifo.sv
// Valid/ready FIFO with registered count and almost-full flag.
// Optional same-cycle bypass when empty: define VALID_PIPE_FIFO_BYPASS_EN.
module valid_pipe_fifo
  import valid_pipe_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [DATA_W-1:0]       up_data,
  input  logic                    up_valid,
  output logic                    up_ready,
  output logic [DATA_W-1:0]       down_data,
  output logic                    down_valid,
  input  logic                    down_ready,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    afull
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_LVL);

  generate
    if (!depth_ok(DEPTH)) begin : g_bad_depth
      $error("valid_pipe_fifo: DEPTH must be a power of two >= 2");
    end
    if ((AFULL_LVL < 1) || (AFULL_LVL > DEPTH)) begin : g_bad_afull
      $error("valid_pipe_fifo: AFULL_LVL must be in 1..DEPTH");
    end
    if ((DATA_W < 1) || (DATA_W > 256)) begin : g_bad_width
      $error("valid_pipe_fifo: DATA_W must be in 1..256");
    end
  endgenerate

  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] mem_rdata;
  logic              empty;
  logic              push;
  logic              pop;
  logic              bypass_take;
  logic              wr_en;
  logic              rd_adv;

  // Handshake: a beat transfers on a rising edge only when valid and ready are both
  // high; a valid beat holds its data until taken, and ready never looks at valid.
  assign empty    = (count_q == '0);
  assign up_ready = rst_n & (count_q < FULL_C) & ~flush;
  assign push     = up_valid & up_ready;

`ifdef VALID_PIPE_FIFO_BYPASS_EN
  assign down_valid  = rst_n & ~flush & (~empty | up_valid);
  assign down_data   = empty ? up_data : mem_rdata;
  // An empty FIFO handing the beat straight through stores nothing.
  assign bypass_take = empty & push & down_ready;
`else
  assign down_valid  = ~flush & ~empty;
  assign down_data   = mem_rdata;
  assign bypass_take = 1'b0;
`endif

  assign pop    = down_valid & down_ready;
  assign wr_en  = push & ~bypass_take;
  assign rd_adv = pop & ~bypass_take;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) begin
        wptr_d = wptr_q + PTR_W'(1);
      end
      if (rd_adv) begin
        rptr_d = rptr_q + PTR_W'(1);
      end
      case ({wr_en, rd_adv})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign afull = (count_q >= AFULL_C);

  valid_pipe_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (wptr_q),
    .wdata_i (up_data),
    .raddr_i (rptr_q),
    .rdata_o (mem_rdata)
  );

endmodule
